// File: rtl/data_memory_pipelined.sv
// Byte-addressable single-port data memory: valid/ready requests, registered load response (1 cycle, 2 if split).
// Misaligned words take two row cycles with reqReady low for the second; bad mode or out-of-range requests pulse error.
module data_memory_pipelined #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  wrEnable,
    input  logic [1:0]            numberOfByte,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  outValid,
    output logic                  error
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int ROWS  = DEPTH / BYTES;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int OFF_W = $clog2(BYTES);
    localparam logic [ADDR_WIDTH:0]   DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BYTES_A = ADDR_WIDTH'(BYTES);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t                state_q, state_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] st_dat_q, st_dat_d;
    logic                  load_q, load_d;
    logic [1:0]            mode_q, mode_d;
    logic                  rsp_pend_q, rsp_pend_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovld_q, ovld_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem_q [ROWS];

    logic                  accept, req_err, req_split;
    logic [OFF_W-1:0]      req_off;
    logic [ROW_W-1:0]      req_row;
    logic [ADDR_WIDTH:0]   last_addr;

    logic                  acc_en, acc_wr, acc_byte, acc_second;
    logic [ROW_W-1:0]      acc_row;
    logic [OFF_W-1:0]      acc_off;
    logic [DATA_WIDTH-1:0] acc_dat;
    logic [DATA_WIDTH-1:0] rd_row;
    logic                  wr_en;
    logic [BYTES-1:0]      wr_be;
    logic [DATA_WIDTH-1:0] wr_dat;

    assign reqReady  = (state_q == IDLE) && !reset;
    assign accept    = reqValid && reqReady;
    assign req_off   = OFF_W'(address % BYTES_A);
    assign req_row   = ROW_W'(address / BYTES_A);
    assign last_addr = {1'b0, address}
                     + ((numberOfByte == 2'b00) ? (ADDR_WIDTH + 1)'(BYTES - 1) : '0);
    assign req_err   = (numberOfByte == 2'b11) || (last_addr >= DEPTH_A);
    assign req_split = (numberOfByte == 2'b00) && (req_off != '0);

    // Request sequencing: which row is touched this cycle and what response is owed next cycle.
    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        row_d      = row_q;
        st_dat_d   = st_dat_q;
        load_d     = load_q;
        mode_d     = mode_q;
        rsp_pend_d = 1'b0;
        rsp_err_d  = 1'b0;
        acc_en     = 1'b0;
        acc_wr     = 1'b0;
        acc_byte   = 1'b0;
        acc_second = 1'b0;
        acc_row    = req_row;
        acc_off    = req_off;
        acc_dat    = dataIn;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_d   = !wrEnable;
                    mode_d   = numberOfByte;
                    off_d    = req_off;
                    row_d    = req_row + ROW_W'(1);
                    st_dat_d = dataIn;
                    if (req_err) begin
                        rsp_pend_d = 1'b1;
                        rsp_err_d  = 1'b1;
                    end else begin
                        acc_en   = 1'b1;
                        acc_wr   = wrEnable;
                        acc_byte = (numberOfByte != 2'b00);
                        if (req_split) begin
                            state_d = SPLIT;
                        end else begin
                            rsp_pend_d = 1'b1;
                        end
                    end
                end
            end
            SPLIT: begin
                acc_en     = 1'b1;
                acc_wr     = !load_q;
                acc_second = 1'b1;
                acc_row    = row_q;
                acc_off    = off_q;
                acc_dat    = st_dat_q;
                rsp_pend_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word byte j lives at row lane (off + j) mod BYTES; the first access covers j < BYTES-off.
    always_comb begin
        rd_row = mem_q[acc_row];
        wr_en  = acc_en && acc_wr && !reset;
        wr_be  = '0;
        wr_dat = '0;
        asm_d  = asm_q;
        for (int b = 0; b < BYTES; b++) begin
            if (acc_byte) begin
                wr_be[b]         = (b == int'(acc_off));
                wr_dat[8*b +: 8] = acc_dat[7:0];
            end else begin
                wr_be[b]         = acc_second ? (b < int'(acc_off)) : (b >= int'(acc_off));
                wr_dat[8*b +: 8] = acc_dat[8*((b + BYTES - int'(acc_off)) % BYTES) +: 8];
            end
            if (acc_en && !acc_wr && (acc_second == (b >= BYTES - int'(acc_off)))) begin
                asm_d[8*b +: 8] = rd_row[8*((b + int'(acc_off)) % BYTES) +: 8];
            end
        end
    end

    always_comb begin
        ovld_d = rsp_pend_q && load_q;
        err_d  = rsp_pend_q && rsp_err_q;
        dout_d = dout_q;
        if (ovld_d) begin
            if (rsp_err_q) begin
                dout_d = '0;
            end else begin
                case (mode_q)
                    2'b01:   dout_d = {{(DATA_WIDTH - 8){1'b0}}, asm_q[7:0]};
                    2'b10:   dout_d = {{(DATA_WIDTH - 8){asm_q[7]}}, asm_q[7:0]};
                    default: dout_d = asm_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            off_q      <= '0;
            row_q      <= '0;
            load_q     <= 1'b0;
            mode_q     <= 2'b00;
            rsp_pend_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            dout_q     <= '0;
            ovld_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            row_q      <= row_d;
            load_q     <= load_d;
            mode_q     <= mode_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_err_q  <= rsp_err_d;
            dout_q     <= dout_d;
            ovld_q     <= ovld_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        st_dat_q <= st_dat_d;
        asm_q    <= asm_d;
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be[b]) begin
                    mem_q[acc_row][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    assign dataOut  = dout_q;
    assign outValid = ovld_q;
    assign error    = err_q;
endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: directed scenarios plus randomized requests against a byte-array model.
module tb_data_memory_pipelined;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqValid;
    logic          reqReady;
    logic          wrEnable;
    logic [1:0]    numberOfByte;
    logic [AW-1:0] address;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] dataOut;
    logic          outValid;
    logic          error;

    int errors = 0;
    int checks = 0;
    logic [7:0] model [DEPTH];

    always #5 clk = ~clk;

    data_memory_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .reqValid(reqValid), .reqReady(reqReady),
        .wrEnable(wrEnable), .numberOfByte(numberOfByte), .address(address),
        .dataIn(dataIn), .dataOut(dataOut), .outValid(outValid), .error(error)
    );

    function automatic bit req_bad(input logic [1:0] mode, input int addr);
        int size;
        size = (mode == 2'b00) ? BYTES : 1;
        return (mode == 2'b11) || (addr + size - 1 >= DEPTH);
    endfunction

    function automatic logic [DW-1:0] exp_load(input logic [1:0] mode, input int addr);
        logic [DW-1:0] r;
        r = '0;
        if (!req_bad(mode, addr)) begin
            if (mode == 2'b00) begin
                for (int i = 0; i < BYTES; i++) r[8*i +: 8] = model[addr + i];
            end else begin
                r[7:0] = model[addr];
                if (mode == 2'b10 && model[addr][7]) r[DW-1:8] = '1;
            end
        end
        return r;
    endfunction

    task automatic model_store(input logic [1:0] mode, input int addr, input logic [DW-1:0] d);
        if (!req_bad(mode, addr)) begin
            if (mode == 2'b00) begin
                for (int i = 0; i < BYTES; i++) model[addr + i] = d[8*i +: 8];
            end else begin
                model[addr] = d[7:0];
            end
        end
    endtask

    // Presents one request, returns 1 time unit after its accepting edge.
    task automatic drive(input logic wr, input logic [1:0] mode, input int addr, input logic [DW-1:0] d);
        reqValid     = 1'b1;
        wrEnable     = wr;
        numberOfByte = mode;
        address      = AW'(addr);
        dataIn       = d;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        if (wr) model_store(mode, addr, d);
    endtask

    // Waits up to max_cyc edges for outValid or error; lat = -1 if nothing arrived.
    task automatic wait_rsp(input int max_cyc, output int lat, output logic ov, output logic er,
                            output logic [DW-1:0] d);
        int i;
        lat = -1; ov = 1'b0; er = 1'b0; d = '0; i = 0;
        while (lat < 0 && i < max_cyc) begin
            @(posedge clk);
            #1;
            i++;
            if (outValid || error) begin
                lat = i; ov = outValid; er = error; d = dataOut;
            end
        end
    endtask

    task automatic test_reset();
        foreach (model[i]) model[i] = 8'h00;
        reset = 1'b1; reqValid = 1'b0; wrEnable = 1'b0;
        numberOfByte = 2'b00; address = '0; dataIn = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (reqReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", reqReady); end
        checks++;
        if (outValid !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL reset_flags: outValid=%b error=%b want 0 0", outValid, error);
        end
        checks++;
        if (dataOut !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", dataOut); end
        reset = 1'b0;
        #1;
        checks++;
        if (reqReady !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", reqReady); end
    endtask

    task automatic test_store_load();
        int lat; logic ov, er; logic [DW-1:0] got;
        drive(1'b1, 2'b00, 'h10, 16'hBEEF);
        checks++;
        if (reqReady !== 1'b1 || outValid !== 1'b0) begin
            errors++; $display("FAIL store_no_stall: ready=%b outValid=%b want 1 0", reqReady, outValid);
        end
        drive(1'b0, 2'b00, 'h10, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (lat != 1 || ov !== 1'b1 || er !== 1'b0) begin
            errors++; $display("FAIL load_latency: lat=%0d ov=%b er=%b want 1 1 0", lat, ov, er);
        end
        checks++;
        if (got !== 16'hBEEF) begin errors++; $display("FAIL load_word: got %h want beef", got); end
        @(posedge clk);
        #1;
        checks++;
        if (outValid !== 1'b0 || dataOut !== 16'hBEEF) begin
            errors++; $display("FAIL hold_data: outValid=%b data=%h want 0 beef", outValid, dataOut);
        end
    endtask

    task automatic test_byte_loads();
        int lat; logic ov, er; logic [DW-1:0] got;
        int            a_tab [3] = '{'h11, 'h11, 'h10};
        logic [1:0]    m_tab [3] = '{2'b01, 2'b10, 2'b10};
        logic [DW-1:0] e_tab [3] = '{16'h00BE, 16'hFFBE, 16'hFFEF};
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, m_tab[k], a_tab[k], '0);
            wait_rsp(4, lat, ov, er, got);
            checks++;
            if (lat != 1 || got !== e_tab[k]) begin
                errors++; $display("FAIL byte_load_%0d: lat=%0d data=%h want 1 %h", k, lat, got, e_tab[k]);
            end
        end
    endtask

    task automatic test_misaligned();
        int lat; logic ov, er; logic [DW-1:0] got;
        drive(1'b1, 2'b00, 'h21, 16'hA55A);
        checks++;
        if (reqReady !== 1'b0) begin errors++; $display("FAIL split_stall: ready=%b want 0", reqReady); end
        @(posedge clk);
        #1;
        checks++;
        if (reqReady !== 1'b1) begin errors++; $display("FAIL split_release: ready=%b want 1", reqReady); end
        drive(1'b0, 2'b01, 'h21, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (got !== 16'h005A) begin errors++; $display("FAIL split_byte_lo: got %h want 005a", got); end
        drive(1'b0, 2'b01, 'h22, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (got !== 16'h00A5) begin errors++; $display("FAIL split_byte_hi: got %h want 00a5", got); end
        drive(1'b0, 2'b00, 'h21, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (lat != 2 || got !== 16'hA55A) begin
            errors++; $display("FAIL split_load: lat=%0d data=%h want 2 a55a", lat, got);
        end
        drive(1'b0, 2'b00, 'h20, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (lat != 1 || got !== 16'h5A00) begin
            errors++; $display("FAIL aligned_neighbour: lat=%0d data=%h want 1 5a00", lat, got);
        end
    endtask

    task automatic test_errors();
        int lat; logic ov, er; logic [DW-1:0] got;
        drive(1'b0, 2'b00, 'hFF, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (lat != 1 || ov !== 1'b1 || er !== 1'b1 || got !== 16'h0000) begin
            errors++; $display("FAIL range_load: lat=%0d ov=%b er=%b data=%h want 1 1 1 0000", lat, ov, er, got);
        end
        drive(1'b1, 2'b11, 'h30, 16'h1111);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (lat != 1 || ov !== 1'b0 || er !== 1'b1) begin
            errors++; $display("FAIL mode_store: lat=%0d ov=%b er=%b want 1 0 1", lat, ov, er);
        end
        drive(1'b0, 2'b01, 'h30, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (er !== 1'b0 || got !== 16'h0000) begin
            errors++; $display("FAIL mode_store_nowrite: er=%b data=%h want 0 0000", er, got);
        end
        drive(1'b0, 2'b01, 'hFF, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (lat != 1 || er !== 1'b0 || ov !== 1'b1) begin
            errors++; $display("FAIL last_byte_ok: lat=%0d ov=%b er=%b want 1 1 0", lat, ov, er);
        end
        drive(1'b0, 2'b00, 'hFE, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (lat != 1 || er !== 1'b0) begin
            errors++; $display("FAIL last_word_ok: lat=%0d er=%b want 1 0", lat, er);
        end
        drive(1'b1, 2'b01, 'h100, 16'h0055);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (lat != 1 || er !== 1'b1 || ov !== 1'b0) begin
            errors++; $display("FAIL byte_beyond_depth: lat=%0d ov=%b er=%b want 1 0 1", lat, ov, er);
        end
    endtask

    task automatic test_reset_split();
        int lat; logic ov, er; logic [DW-1:0] got;
        logic [7:0] old_hi;
        old_hi = model['h32];
        drive(1'b1, 2'b00, 'h31, 16'h1234);
        model['h32] = old_hi;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (reqReady !== 1'b0 || outValid !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL reset_in_split: ready=%b ov=%b er=%b want 0 0 0", reqReady, outValid, error);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (reqReady !== 1'b1) begin errors++; $display("FAIL ready_after_split_reset: got %b want 1", reqReady); end
        drive(1'b0, 2'b01, 'h31, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (got !== 16'h0034) begin errors++; $display("FAIL first_half_kept: got %h want 0034", got); end
        drive(1'b0, 2'b01, 'h32, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (got !== {8'h00, old_hi}) begin
            errors++; $display("FAIL second_half_dropped: got %h want %h", got, {8'h00, old_hi});
        end
    endtask

    task automatic test_byte_store_sign();
        int lat; logic ov, er; logic [DW-1:0] got;
        drive(1'b1, 2'b01, 'h40, 16'h127F);
        drive(1'b0, 2'b10, 'h40, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (lat != 1 || got !== 16'h007F) begin
            errors++; $display("FAIL raw_sign_pos: lat=%0d data=%h want 1 007f", lat, got);
        end
        drive(1'b1, 2'b10, 'h40, 16'hAB80);
        drive(1'b0, 2'b10, 'h40, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (lat != 1 || got !== 16'hFF80) begin
            errors++; $display("FAIL raw_sign_neg: lat=%0d data=%h want 1 ff80", lat, got);
        end
        drive(1'b0, 2'b00, 'h40, '0);
        wait_rsp(4, lat, ov, er, got);
        checks++;
        if (got !== exp_load(2'b00, 'h40)) begin
            errors++; $display("FAIL byte_store_width: got %h want %h", got, exp_load(2'b00, 'h40));
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e0, e1, e2;
        e0 = exp_load(2'b00, 'h10);
        e1 = exp_load(2'b00, 'h20);
        e2 = exp_load(2'b01, 'h41);
        drive(1'b0, 2'b00, 'h10, '0);
        drive(1'b0, 2'b00, 'h20, '0);
        checks++;
        if (outValid !== 1'b1 || dataOut !== e0) begin
            errors++; $display("FAIL b2b_0: ov=%b data=%h want 1 %h", outValid, dataOut, e0);
        end
        drive(1'b0, 2'b01, 'h41, '0);
        checks++;
        if (outValid !== 1'b1 || dataOut !== e1) begin
            errors++; $display("FAIL b2b_1: ov=%b data=%h want 1 %h", outValid, dataOut, e1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (outValid !== 1'b1 || dataOut !== e2) begin
            errors++; $display("FAIL b2b_2: ov=%b data=%h want 1 %h", outValid, dataOut, e2);
        end
    endtask

    task automatic test_random();
        int lat; logic ov, er; logic [DW-1:0] got;
        logic wr; logic [1:0] mode; int addr, r, exp_lat; logic [DW-1:0] d, exp_d; bit bad;
        for (int n = 0; n < 300; n++) begin
            wr   = 1'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 9));
            mode = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            addr = (n % 2 == 1) ? 'h80 + int'($urandom_range(0, 15)) : int'($urandom_range(0, DEPTH + 2));
            d    = DW'($urandom);
            bad  = req_bad(mode, addr);
            exp_d   = wr ? '0 : exp_load(mode, addr);
            exp_lat = bad ? 1 : wr ? -1 : (mode == 2'b00 && addr % BYTES != 0) ? 2 : 1;
            drive(wr, mode, addr, d);
            wait_rsp(3, lat, ov, er, got);
            checks++;
            if (lat != exp_lat || ov !== !wr || er !== bad || (!wr && got !== exp_d)) begin
                errors++;
                $display("FAIL random_%0d: wr=%b mode=%b addr=%h lat=%0d ov=%b er=%b data=%h want lat=%0d ov=%b er=%b data=%h",
                         n, wr, mode, addr, lat, ov, er, got, exp_lat, !wr, bad, exp_d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_loads();
        test_misaligned();
        test_errors();
        test_reset_split();
        test_byte_store_sign();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
